// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge-detects peripheral requests into PENDING,
// masks them, picks the lowest enabled index and holds a one-hot irq until the core's eoi.
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int IRQ_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        axi_awaddr,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [31:0]        axi_wdata,
    input  logic [3:0]         axi_wstrb,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic [31:0]        axi_araddr,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    output logic [31:0]        axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [IRQ_W-1:0]   irq,
    input  logic               eoi
);

    localparam logic [31:0] ADDR_PENDING = 32'h00;
    localparam logic [31:0] ADDR_MASK    = 32'h04;
    localparam logic [31:0] ADDR_ACTIVE  = 32'h08;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;

    typedef enum logic {IDLE, SERVE} state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_hist;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    state_t             r_state;
    logic [4:0]         r_id;
    logic [IRQ_W-1:0]   r_irq;
    logic               r_wr_rdy;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_rd_rdy;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_eoi_clr;
    logic [4:0]         w_sel;
    state_t             w_state_next;
    logic [4:0]         w_id_next;
    logic [IRQ_W-1:0]   w_irq_next;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic [1:0]         w_wr_resp;
    logic [31:0]        w_rd_data;
    logic [1:0]         w_rd_resp;
    logic               w_unused;

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the synchroniser array is a set of real flops, not a RAM, so it is reset like any register.
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_req     = r_pending & r_mask;
    assign w_wr_fire = axi_awvalid && axi_wvalid && r_wr_rdy;
    assign w_rd_fire = axi_arvalid && r_rd_rdy;
    assign w_w1c     = (w_wr_fire && axi_awaddr == ADDR_PENDING) ? axi_wdata[NUM_SRC-1:0] : '0;
    assign w_wr_resp = (axi_awaddr == ADDR_PENDING || axi_awaddr == ADDR_MASK ||
                        axi_awaddr == ADDR_ACTIVE) ? RESP_OKAY : RESP_SLVERR;
    assign w_unused  = ^{axi_wstrb, axi_wdata};

    // A fresh edge outranks a same-cycle W1C or eoi clear of the same bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_w1c & ~w_eoi_clr) | w_rise;
            if (w_wr_fire && axi_awaddr == ADDR_MASK) r_mask <= axi_wdata[NUM_SRC-1:0];
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) w_sel = 5'(i);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_irq   <= '0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
            r_irq   <= w_irq_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_id_next    = r_id;
        w_irq_next   = r_irq;
        w_eoi_clr    = '0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_id_next    = w_sel;
                    w_irq_next   = IRQ_W'(1) << w_sel;
                    w_state_next = SERVE;
                end
            end
            SERVE: begin
                if (eoi) begin
                    w_eoi_clr    = NUM_SRC'(1) << r_id;
                    w_irq_next   = '0;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (axi_araddr)
            ADDR_PENDING: w_rd_data = 32'(r_pending);
            ADDR_MASK:    w_rd_data = 32'(r_mask);
            ADDR_ACTIVE:  w_rd_data = {r_state == SERVE, 26'd0, (r_state == SERVE) ? r_id : 5'd0};
            default:      w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_rdy <= 1'b1;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_wr_fire) begin
            r_wr_rdy <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
        end else if (r_bvalid && axi_bready) begin
            r_wr_rdy <= 1'b1;
            r_bvalid <= 1'b0;
        end
    end

    // Read data is captured at acceptance, so a same-cycle W1C is not visible in it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_rdy <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_rd_fire) begin
            r_rd_rdy <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && axi_rready) begin
            r_rd_rdy <= 1'b1;
            r_rvalid <= 1'b0;
        end
    end

    assign axi_awready = r_wr_rdy;
    assign axi_wready  = r_wr_rdy;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign axi_arready = r_rd_rdy;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign irq         = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register-access vector table, directed interrupt sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int NUM_SRC = 4;
    localparam int IRQ_W   = 32;
    localparam int SYNC    = 2;
    localparam int BOUND   = 50;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] axi_awaddr = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = 4'hF;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [31:0] axi_araddr = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [NUM_SRC-1:0] irq_src = '0;
    logic [IRQ_W-1:0]   irq;
    logic        eoi = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] irq_at_accept;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .IRQ_W(IRQ_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .irq_src(irq_src), .irq(irq), .eoi(eoi)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    logic [3:0]  m_pending, m_mask;
    bit          m_busy;
    int          m_id;
    logic [31:0] m_irq;
    logic [3:0]  m_smp [SYNC+1];   // m_smp[k]: irq_src as sampled k+1 edges ago
    bit          m_wrdy, m_bvalid, m_rrdy, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    function automatic bit reg_known(input logic [31:0] a);
        return (a == 32'h0) || (a == 32'h4) || (a == 32'h8);
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] m_reg_value(input logic [31:0] a);
        case (a)
            32'h0:   return {28'd0, m_pending};
            32'h4:   return {28'd0, m_mask};
            32'h8:   return m_busy ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pending = '0; m_mask = '0; m_busy = 0; m_id = 0; m_irq = '0;
        for (int k = 0; k <= SYNC; k++) m_smp[k] = '0;
        m_wrdy = 1; m_bvalid = 0; m_rrdy = 1; m_rvalid = 0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    endtask

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_step();
        logic [3:0] rise, req, clr_w1c, clr_eoi;
        bit wr_fire, rd_fire;
        rise    = m_smp[SYNC-1] & ~m_smp[SYNC];
        req     = m_pending & m_mask;
        wr_fire = axi_awvalid && axi_wvalid && m_wrdy;
        rd_fire = axi_arvalid && m_rrdy;
        clr_w1c = (wr_fire && axi_awaddr == 32'h0) ? axi_wdata[3:0] : 4'h0;
        clr_eoi = (m_busy && eoi) ? 4'(1 << m_id) : 4'h0;
        if (rd_fire) begin
            m_rdata = m_reg_value(axi_araddr);
            m_rresp = reg_known(axi_araddr) ? 2'b00 : 2'b10;
            m_rvalid = 1; m_rrdy = 0;
        end else if (m_rvalid && axi_rready) begin
            m_rvalid = 0; m_rrdy = 1;
        end
        if (wr_fire) begin
            m_bresp = reg_known(axi_awaddr) ? 2'b00 : 2'b10;
            m_bvalid = 1; m_wrdy = 0;
            if (axi_awaddr == 32'h4) m_mask = axi_wdata[3:0];
        end else if (m_bvalid && axi_bready) begin
            m_bvalid = 0; m_wrdy = 1;
        end
        if (!m_busy && req != 0) begin
            m_id = lowest(req); m_busy = 1; m_irq = 32'(1) << m_id;
        end else if (m_busy && eoi) begin
            m_busy = 0; m_irq = '0;
        end
        m_pending = (m_pending & ~clr_w1c & ~clr_eoi) | rise;
        for (int k = SYNC; k > 0; k--) m_smp[k] = m_smp[k-1];
        m_smp[0] = irq_src;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: no handshake within %0d cycles", name, BOUND);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        eoi = 1'b0;
        check("cyc_irq", irq, m_irq);
        check("cyc_awready", 32'(axi_awready), 32'(m_wrdy));
        check("cyc_wready", 32'(axi_wready), 32'(m_wrdy));
        check("cyc_bvalid", 32'(axi_bvalid), 32'(m_bvalid));
        check("cyc_arready", 32'(axi_arready), 32'(m_rrdy));
        check("cyc_rvalid", 32'(axi_rvalid), 32'(m_rvalid));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        irq_src = '0; eoi = 1'b0;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_arvalid = 1'b0; axi_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
        while (!(axi_awready && axi_wready)) begin
            if (n == BOUND) begin timeout("wr_accept"); break; end
            tick(); n++;
        end
        tick();
        irq_at_accept = irq;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n = 0;
        while (!axi_bvalid) begin
            if (n == BOUND) begin timeout("wr_bvalid"); break; end
            tick(); n++;
        end
        resp = axi_bresp;
        tick();
        axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b1;
        while (!axi_arready) begin
            if (n == BOUND) begin timeout("rd_accept"); break; end
            tick(); n++;
        end
        tick();
        axi_arvalid = 1'b0;
        n = 0;
        while (!axi_rvalid) begin
            if (n == BOUND) begin timeout("rd_rvalid"); break; end
            tick(); n++;
        end
        data = axi_rdata;
        resp = axi_rresp;
        tick();
        axi_rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        tbl[0]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0, 2'b00};
        tbl[1]  = '{1'b0, 32'h04, 32'h0,         32'hF, 2'b00};
        tbl[2]  = '{1'b1, 32'h04, 32'h5,         32'h0, 2'b00};
        tbl[3]  = '{1'b0, 32'h04, 32'h0,         32'h5, 2'b00};
        tbl[4]  = '{1'b0, 32'h00, 32'h0,         32'h0, 2'b00};
        tbl[5]  = '{1'b0, 32'h08, 32'h0,         32'h0, 2'b00};
        tbl[6]  = '{1'b0, 32'h10, 32'h0,         32'h0, 2'b10};
        tbl[7]  = '{1'b1, 32'h10, 32'hFFFF,      32'h0, 2'b10};
        tbl[8]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 32'h0, 2'b00};
        tbl[9]  = '{1'b0, 32'h08, 32'h0,         32'h0, 2'b00};
        tbl[10] = '{1'b0, 32'h04, 32'h0,         32'h5, 2'b00};
        tbl[11] = '{1'b1, 32'h04, 32'h0,         32'h0, 2'b00};
        tbl[12] = '{1'b0, 32'h04, 32'h0,         32'h0, 2'b00};

        // Reset state
        reset_dut();
        check("rst_irq", irq, 32'h0);
        check("rst_awready", 32'(axi_awready), 32'h1);
        check("rst_wready", 32'(axi_wready), 32'h1);
        check("rst_arready", 32'(axi_arready), 32'h1);
        check("rst_bvalid", 32'(axi_bvalid), 32'h0);
        check("rst_rvalid", 32'(axi_rvalid), 32'h0);

        // Register access table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, r);
            end else begin
                axi_read(tbl[i].addr, d, r);
                check($sformatf("vec%0d_rdata", i), d, tbl[i].exp_data);
            end
            check($sformatf("vec%0d_resp", i), 32'(r), 32'(tbl[i].exp_resp));
        end

        // T1: single source, latency from input change to irq
        reset_dut();
        axi_write(32'h4, 32'h2, r);
        irq_src = 4'b0010;
        tick(); tick();
        check("t1_irq_e2", irq, 32'h0);
        tick();
        check("t1_irq_e3", irq, 32'h0);
        tick();
        check("t1_irq_e4", irq, 32'h2);
        axi_read(32'h0, d, r);
        check("t1_pending", d, 32'h2);
        axi_read(32'h8, d, r);
        check("t1_active", d, 32'h8000_0001);
        eoi = 1'b1; tick();
        check("t1_eoi_drop", irq, 32'h0);
        axi_read(32'h0, d, r);
        check("t1_pending_clr", d, 32'h0);

        // T2: simultaneous sources, priority and dead cycle
        irq_src = '0; ticks(4);
        axi_write(32'h4, 32'hF, r);
        irq_src = 4'b1010; ticks(4);
        check("t2_first", irq, 32'h2);
        eoi = 1'b1; tick();
        check("t2_dead", irq, 32'h0);
        tick();
        check("t2_second", irq, 32'h8);
        eoi = 1'b1; tick();
        check("t2_eoi2", irq, 32'h0);
        tick();
        check("t2_idle", irq, 32'h0);
        axi_read(32'h0, d, r);
        check("t2_pending", d, 32'h0);

        // T3: masked source becomes enabled
        irq_src = '0; ticks(4);
        axi_write(32'h4, 32'h0, r);
        irq_src = 4'b0001; ticks(5);
        check("t3_masked", irq, 32'h0);
        axi_read(32'h0, d, r);
        check("t3_pending", d, 32'h1);
        axi_write(32'h4, 32'h1, r);
        check("t3_irq_at_mask_edge", irq_at_accept, 32'h0);
        check("t3_irq_after_mask", irq, 32'h1);
        eoi = 1'b1; tick();

        // T4: MASK and W1C during service do not drop irq
        irq_src = '0; ticks(4);
        axi_write(32'h4, 32'h4, r);
        irq_src = 4'b0100; ticks(4);
        check("t4_irq", irq, 32'h4);
        axi_write(32'h4, 32'h0, r);
        check("t4_hold_mask", irq, 32'h4);
        axi_write(32'h0, 32'h4, r);
        check("t4_hold_w1c", irq, 32'h4);
        axi_read(32'h0, d, r);
        check("t4_pending_w1c", d, 32'h0);
        eoi = 1'b1; tick();
        check("t4_eoi", irq, 32'h0);
        ticks(2);
        check("t4_stay_idle", irq, 32'h0);

        // T5: re-edge collides with eoi clear, set wins
        axi_write(32'h4, 32'h4, r);
        irq_src = '0; ticks(4);
        irq_src = 4'b0100; ticks(4);
        check("t5_irq", irq, 32'h4);
        irq_src = '0; ticks(4);
        irq_src = 4'b0100;
        tick(); tick();
        eoi = 1'b1; tick();
        check("t5_dead", irq, 32'h0);
        tick();
        check("t5_reassert", irq, 32'h4);
        axi_read(32'h0, d, r);
        check("t5_pending", d, 32'h4);
        eoi = 1'b1; tick();
        check("t5_eoi", irq, 32'h0);

        // T6: back-pressure on B channel, then reset during service
        irq_src = '0; ticks(4);
        axi_awaddr = 32'h4; axi_wdata = 32'h3; axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
        tick();
        axi_wdata = 32'hF;
        for (int i = 0; i < 5; i++) begin
            check("t6_bvalid_held", 32'(axi_bvalid), 32'h1);
            check("t6_no_second_accept", 32'(axi_awready), 32'h0);
            tick();
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        check("t6_bvalid_done", 32'(axi_bvalid), 32'h0);
        check("t6_ready_back", 32'(axi_awready), 32'h1);
        axi_read(32'h4, d, r);
        check("t6_mask", d, 32'h3);
        irq_src = 4'b0001; ticks(4);
        check("t6_serve", irq, 32'h1);
        resetn = 1'b0;
        irq_src = '0;
        #1;
        check("t6_async_reset", irq, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        axi_read(32'h0, d, r);
        check("t6_pending_lost", d, 32'h0);
        axi_read(32'h4, d, r);
        check("t6_mask_lost", d, 32'h0);

        // Randomized traffic against the model
        reset_dut();
        for (int it = 0; it < 600; it++) begin
            int sel;
            logic [31:0] addr;
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       addr = 32'h0;
                1:       addr = 32'h4;
                2:       addr = 32'h8;
                default: addr = 32'h10;
            endcase
            if (sel < 6) begin
                irq_src = irq_src ^ (4'($urandom) & 4'($urandom));
                eoi = ($urandom_range(0, 3) == 0);
                tick();
            end else if (sel < 8) begin
                axi_write(addr, $urandom, r);
                check("rnd_bresp", 32'(r), 32'(m_bresp));
            end else begin
                axi_read(addr, d, r);
                check("rnd_rdata", d, m_rdata);
                check("rnd_rresp", 32'(r), 32'(m_rresp));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
